muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Multi-cycle sequencer for RV32M multiply/divide ops that the single-cycle ALU does not cover.
//  Sits beside the ALU in EX: accepts one op via valid/ready and runs a shift-add or restoring-divide loop.
//  Applies sign fix-up, then returns a 32-bit result with a one-cycle done pulse.
//  The pipeline stalls EX while busy=1; flush aborts the op on a branch mispredict or trap.
// PARAMETERS
//  XLEN    32  operand/result width; only 32 is supported
//  CNT_W   5   iteration counter width (2^CNT_W == XLEN)
// PORTS
//  clk       in   1     single clock, rising edge
//  rst       in   1     synchronous active-high reset
//  valid     in   1     op request; sampled only while ready=1
//  op        in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  rs1       in   32    operand A (multiplicand / dividend)
//  rs2       in   32    operand B (multiplier / divisor)
//  flush     in   1     abort the current op; no done is produced
//  ready     out  1     1 only in IDLE; accept = valid & ready & ~flush
//  busy      out  1     1 in CALC, FIX and DONE
//  done      out  1     one-cycle pulse; result valid this cycle
//  result    out  32    final value; held until the next accept
// BEHAVIOUR
//  Reset (sync, rst=1 at a clk edge): state=IDLE, ready=1, busy=0, done=0, result=0, counter=0.
//   Any in-flight op is discarded.
//  FSM states: IDLE, CALC, FIX, DONE.
//   IDLE -accept, normal->  CALC
//   IDLE -accept, special-> DONE
//   CALC -counter==31-> FIX (else stay, counter++)
//   FIX -> DONE
//   DONE -> IDLE
//  Normal latency: accept in cycle T; CALC runs T+1..T+32 (counter 0..31); FIX in T+33.
//   done=1 and result valid in T+34; ready=1 again in T+35.
//  Special cases (decided at accept, no iteration): done in T+1, ready in T+2.
//   - DIV/DIVU by 0: quotient 0xFFFFFFFF.
//   - REM/REMU by 0: remainder = rs1.
//   - DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000.
//   - REM 0x80000000 % 0xFFFFFFFF: remainder 0.
//  Operand prep at accept: take magnitudes of the signed operands.
//   - MUL, MULH, DIV, REM: both operands signed.
//   - MULHSU: rs1 signed, rs2 unsigned.
//   - MULHU, DIVU, REMU: both unsigned.
//   Latch neg_q = sA^sB and neg_r = sA, where sA/sB are the signs of signed-treated operands.
//  Multiply: 64-bit product register, radix-2; one conditional add of the multiplicand + shift per CALC cycle.
//  Divide: restoring; 33-bit partial-remainder subtract per cycle; quotient bits shift in LSB-first-filled order.
//  FIX: for multiply, negate the 64-bit product if neg_q; then take
//   - low 32 bits for MUL,
//   - high 32 bits for MULH/MULHSU/MULHU.
//   For divide: negate the quotient if neg_q (DIV), negate the remainder if neg_r (REM).
//   All arithmetic is mod 2^32 / 2^64; there are no overflow flags.
//  The result register updates only on entry to DONE; it is stable at all other times.
//  Flush: in any state, flush=1 at an edge sends state to IDLE next cycle.
//   No done pulse is produced and result keeps its old value.
//   In IDLE, flush blocks acceptance even when valid=1.
//  Flush in the same cycle as DONE: the done pulse is still emitted (the op has already retired); state goes to IDLE.
//  rst has priority over flush; flush has priority over valid.
//  Inputs rs1/rs2/op are sampled only at accept; later changes have no effect.
// TESTING
//  1. MUL rs1=7, rs2=0xFFFFFFFD, accept T -> done@T+34, result=0xFFFFFFEB; ready=0 T+1..T+34.
//  2. MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//  3. DIVU rs2=0 -> done@T+1, 0xFFFFFFFF; REM rs1=0x1234, rs2=0 -> done@T+1, 0x1234.
//  4. DIV 0x80000000/0xFFFFFFFF -> 0x80000000@T+1; REM -7 % 2 -> 0xFFFFFFFF@T+34; DIV -7/2 -> 0xFFFFFFFD.
//  5. Flush when counter==10 -> no done ever, ready=1 next cycle, result unchanged.
//     Then DIVU 100/7 -> 14 @ +34.
//  6. rst=1 mid-CALC -> next cycle ready=1, busy=0, result=0; valid+flush in IDLE -> no accept.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX stage and the multi-cycle mul/div sequencer.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            ready;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output valid, op, rs1, rs2, flush,
    input  ready, busy, done, result
  );

  modport slave (
    input  valid, op, rs1, rs2, flush,
    output ready, busy, done, result
  );
endinterface

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle sequencer: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up and a one-cycle done pulse.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                accept;
  logic                a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div0, ovf, special;
  logic [XLEN-1:0]     special_res;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_step;
  logic [XLEN:0]       rem_sh, trial;
  logic [2*XLEN-1:0]   div_step;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     fix_res;

  assign accept   = bus.valid & ~bus.flush & (state_q == S_IDLE);
  assign a_signed = bus.op[2] ? ~bus.op[0] : (bus.op != 3'd3);
  assign b_signed = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
  assign sa       = a_signed & bus.rs1[XLEN-1];
  assign sb       = b_signed & bus.rs2[XLEN-1];
  assign mag_a    = sa ? -bus.rs1 : bus.rs1;
  assign mag_b    = sb ? -bus.rs2 : bus.rs2;

  assign div0 = bus.op[2] & (bus.rs2 == '0);
  assign ovf  = bus.op[2] & ~bus.op[0] & (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (bus.rs2 == '1);
  assign special = div0 | ovf;
  // REM ops have op[1]=1; signed overflow yields quotient rs1 (0x80000000) and remainder 0.
  assign special_res = bus.op[1] ? (div0 ? bus.rs1 : '0) : (div0 ? '1 : bus.rs1);

  // Multiply: acc = {partial high, remaining multiplier bits}; add then shift right.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_q[0]}} & b_q};
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient}; shift left, trial-subtract.
  assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign trial    = rem_sh - {1'b0, b_q};
  assign div_step = trial[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  assign prod_fix = negq_q ? -acc_q : acc_q;

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'd0:       fix_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       fix_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5: fix_res = negq_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      default:    fix_res = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = bus.op;
          negq_d = sa ^ sb;
          negr_d = sa;
          cnt_d  = '0;
          if (bus.op[2]) begin
            b_d   = mag_b;
            acc_d = {{XLEN{1'b0}}, mag_a};
          end else begin
            b_d   = mag_a;
            acc_d = {{XLEN{1'b0}}, mag_b};
          end
          if (special) begin
            state_d  = S_DONE;
            result_d = special_res;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_step : mul_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == '1) state_d = S_FIX;
      end
      S_FIX: begin
        state_d  = S_DONE;
        result_d = fix_res;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything but reset; a pending result write is dropped.
    if (bus.flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign bus.ready  = (state_q == S_IDLE);
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed checks of muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  muldiv_seq_if #(.XLEN(32)) bus ();

  muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op >= 3'd4 && b == 32'd0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = (sa * sb) >>> 32; return sp[31:0]; end
      3'd2: begin sp = (sa * longint'(ub)) >>> 32; return sp[31:0]; end
      3'd3: begin up = (ua * ub) >> 32; return up[31:0]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sp = sa % sb; return sp[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op from IDLE and follow it to its done pulse.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned lat, exp_lat;
    logic [31:0] exp, prev;
    logic saw_ready, res_moved;
    exp     = ref_result(op, a, b);
    exp_lat = is_special(op, a, b) ? 1 : 34;
    @(negedge clk);
    check("ready_pre", bus.ready, 1);
    prev = bus.result;
    bus.valid = 1'b1; bus.op = op; bus.rs1 = a; bus.rs2 = b;
    @(negedge clk);
    bus.valid = 1'b0; bus.op = 3'($urandom); bus.rs1 = $urandom; bus.rs2 = $urandom;
    lat = 1; saw_ready = 1'b0; res_moved = 1'b0;
    while (!bus.done && lat < 100) begin
      if (bus.ready) saw_ready = 1'b1;
      if (bus.result !== prev) res_moved = 1'b1;
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency op%0d", op), lat, exp_lat);
    check("ready_low_while_busy", saw_ready, 0);
    check("result_held_until_done", res_moved, 0);
    check($sformatf("result op%0d a=%h b=%h", op, a, b), bus.result, exp);
    @(negedge clk);
    check("ready_after", bus.ready, 1);
    check("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev, a, b;
    logic [2:0] op;
    logic saw_done;
    int unsigned sel;
    bus.valid = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.rs1 = '0; bus.rs2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd55, 32'd0);
    run_op(3'd6, 32'h1234, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, -32'sd7, 32'd2);
    run_op(3'd4, -32'sd7, 32'd2);
    run_op(3'd7, 32'hFFFF_FFFF, 32'd10);

    // Flush at counter==10: no done, result kept.
    @(negedge clk);
    prev = bus.result;
    bus.valid = 1'b1; bus.op = 3'd5; bus.rs1 = 32'd999; bus.rs2 = 32'd3;
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_ready", bus.ready, 1);
    check("flush_result_kept", bus.result, prev);
    saw_done = 1'b0;
    repeat (40) begin
      if (bus.done) saw_done = 1'b1;
      @(negedge clk);
    end
    check("flush_no_done", saw_done, 0);
    run_op(3'd5, 32'd100, 32'd7);

    // Flush coinciding with DONE still shows the pulse.
    @(negedge clk);
    bus.valid = 1'b1; bus.op = 3'd4; bus.rs1 = 32'd5; bus.rs2 = 32'd0;
    @(negedge clk);
    bus.valid = 1'b0;
    check("done_with_flush", bus.done, 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("done_flush_ready", bus.ready, 1);
    check("done_flush_result", bus.result, 32'hFFFF_FFFF);

    // Reset mid-CALC.
    bus.valid = 1'b1; bus.op = 3'd0; bus.rs1 = 32'd3; bus.rs2 = 32'd4;
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_mid_calc", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", bus.ready, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_result", bus.result, 0);

    // valid together with flush in IDLE must not be accepted.
    bus.valid = 1'b1; bus.flush = 1'b1; bus.op = 3'd5; bus.rs1 = 32'd1; bus.rs2 = 32'd0;
    @(negedge clk);
    bus.valid = 1'b0; bus.flush = 1'b0;
    check("vflush_ready", bus.ready, 1);
    check("vflush_busy", bus.busy, 0);
    check("vflush_done", bus.done, 0);
    @(negedge clk);
    check("vflush_no_late_done", bus.done, 0);

    for (int i = 0; i < 48; i++) begin
      op  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      a = $urandom; b = $urandom;
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300) - 150; b = $urandom_range(0, 20) - 10; end
        3: b = $urandom_range(1, 255);
        default: ;
      endcase
      run_op(op, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
